// File: rtl/lock_attempt_guard_if.sv
// Signal bundle between the push-button front end / lock compare stage and lock_attempt_guard.
interface lock_attempt_guard_if #(
    parameter int unsigned FW = 2,
    parameter int unsigned TW = 6
);
    logic          tick;
    logic          ent_req;
    logic          chk_valid;
    logic          chk_match;
    logic          clr_alarm;
    logic          ent_grant;
    logic          lockout;
    logic          alarm;
    logic [FW-1:0] fail_cnt;
    logic [TW-1:0] remain;

    modport master (
        output tick, ent_req, chk_valid, chk_match, clr_alarm,
        input  ent_grant, lockout, alarm, fail_cnt, remain
    );

    modport slave (
        input  tick, ent_req, chk_valid, chk_match, clr_alarm,
        output ent_grant, lockout, alarm, fail_cnt, remain
    );
endinterface

// File: rtl/lock_attempt_guard.sv
// Gates ent presses to the lock FSM, counts wrong codes, runs a timed lockout
// and latches an alarm after repeated lockouts until an admin clear.
module lock_attempt_guard #(
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_SEC = 30,
    parameter int unsigned ALARM_LIMIT = 2,
    parameter int unsigned FW          = 2,
    parameter int unsigned TW          = 6
) (
    input  logic                clk,
    input  logic                rst,
    lock_attempt_guard_if.slave bus
);
    typedef enum logic [1:0] {
        READY   = 2'd0,
        LOCKOUT = 2'd1,
        ALARM   = 2'd2
    } state_t;

    localparam logic [FW:0]   MAX_FAIL_W  = (FW+1)'(MAX_FAIL);
    localparam logic [FW:0]   ALARM_W     = (FW+1)'(ALARM_LIMIT);
    localparam logic [FW-1:0] MAX_FAIL_S  = FW'(MAX_FAIL);
    localparam logic [FW-1:0] ALARM_S     = FW'(ALARM_LIMIT);
    localparam logic [TW-1:0] LOCKOUT_T   = TW'(LOCKOUT_SEC);

    state_t        state_q, state_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [FW-1:0] lock_q, lock_d;
    logic [TW-1:0] remain_q, remain_d;
    logic          grant_q, grant_d;
    logic [FW:0]   fail_inc, lock_inc;

    // One extra bit so the +1 comparison against the limits cannot wrap.
    assign fail_inc = {1'b0, fail_q} + (FW+1)'(1);
    assign lock_inc = {1'b0, lock_q} + (FW+1)'(1);

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        lock_d   = lock_q;
        remain_d = remain_q;
        grant_d  = 1'b0;
        unique case (state_q)
            READY: begin
                grant_d = bus.ent_req;
                if (bus.chk_valid) begin
                    if (bus.chk_match) begin
                        fail_d = '0;
                        lock_d = '0;
                    end else if (fail_inc < MAX_FAIL_W) begin
                        fail_d = fail_inc[FW-1:0];
                    end else begin
                        fail_d = MAX_FAIL_S;
                        if (lock_inc < ALARM_W) begin
                            state_d  = LOCKOUT;
                            remain_d = LOCKOUT_T;
                            lock_d   = lock_inc[FW-1:0];
                        end else begin
                            state_d  = ALARM;
                            remain_d = '0;
                            lock_d   = ALARM_S;
                        end
                    end
                end
            end
            LOCKOUT: begin
                if (bus.tick) begin
                    if (remain_q <= TW'(1)) begin
                        state_d  = READY;
                        remain_d = '0;
                        fail_d   = '0;
                    end else begin
                        remain_d = remain_q - TW'(1);
                    end
                end
            end
            ALARM: begin
                if (bus.clr_alarm) begin
                    state_d  = READY;
                    fail_d   = '0;
                    lock_d   = '0;
                    remain_d = '0;
                end
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= READY;
            fail_q   <= '0;
            lock_q   <= '0;
            remain_q <= '0;
            grant_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            lock_q   <= lock_d;
            remain_q <= remain_d;
            grant_q  <= grant_d;
        end
    end

    assign bus.ent_grant = grant_q;
    assign bus.lockout   = (state_q != READY);
    assign bus.alarm     = (state_q == ALARM);
    assign bus.fail_cnt  = fail_q;
    assign bus.remain    = remain_q;
endmodule

// File: tb/tb_lock_attempt_guard.sv
// Scoreboard bench for lock_attempt_guard: expected outputs are queued as each
// stimulus cycle is driven and popped for comparison one clock later.
module tb_lock_attempt_guard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lock_attempt_guard_if #(.FW(2), .TW(6)) bus ();

    lock_attempt_guard #(
        .MAX_FAIL(3), .LOCKOUT_SEC(30), .ALARM_LIMIT(2), .FW(2), .TW(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       g;
        logic       lo;
        logic       al;
        logic [1:0] fc;
        logic [5:0] rm;
    } exp_t;

    typedef struct packed {
        logic r;
        logic t;
        logic er;
        logic cv;
        logic cm;
        logic ca;
    } stim_t;

    exp_t        sb[$];
    stim_t       pst[$];
    exp_t        pex[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    function automatic exp_t mk(input logic g, input logic lo, input logic al,
                                input int unsigned fc, input int unsigned rm);
        exp_t e;
        e.g  = g;
        e.lo = lo;
        e.al = al;
        e.fc = 2'(fc);
        e.rm = 6'(rm);
        return e;
    endfunction

    function automatic stim_t st(input logic r, input logic t, input logic er,
                                 input logic cv, input logic cm, input logic ca);
        stim_t s;
        s.r = r; s.t = t; s.er = er; s.cv = cv; s.cm = cm; s.ca = ca;
        return s;
    endfunction

    function automatic exp_t sample();
        exp_t o;
        o.g  = bus.ent_grant;
        o.lo = bus.lockout;
        o.al = bus.alarm;
        o.fc = bus.fail_cnt;
        o.rm = bus.remain;
        return o;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("grant=%0b lockout=%0b alarm=%0b fail_cnt=%0d remain=%0d",
                         v.g, v.lo, v.al, v.fc, v.rm);
    endfunction

    task automatic drive(input stim_t s);
        rst           = s.r;
        bus.tick      = s.t;
        bus.ent_req   = s.er;
        bus.chk_valid = s.cv;
        bus.chk_match = s.cm;
        bus.clr_alarm = s.ca;
    endtask

    task automatic add(input stim_t s, input exp_t e);
        pst.push_back(s);
        pex.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        int unsigned idx = 0;
        add(st(1,0,0,0,0,0), mk(0,0,0,0,0));
        add(st(1,0,0,0,0,0), mk(0,0,0,0,0));
        add(st(0,0,1,0,0,0), mk(1,0,0,0,0));
        add(st(0,0,0,0,0,0), mk(0,0,0,0,0));
        add(st(0,0,0,0,0,0), mk(0,0,0,0,0));
        while (pst.size() > 0) begin
            drive(pst.pop_front());
            sb.push_back(pex.pop_front());
            cyc();
            e = sb.pop_front(); got = sample(); n_total++;
            if (got !== e) $display("FAIL reset step%0d got %s want %s", idx, fmt(got), fmt(e));
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_fail_recover();
        exp_t e, got;
        int unsigned idx = 0;
        add(st(0,0,0,1,0,0), mk(0,0,0,1,0));
        add(st(0,0,0,1,0,0), mk(0,0,0,2,0));
        add(st(0,0,0,1,1,0), mk(0,0,0,0,0));
        add(st(0,0,0,0,0,0), mk(0,0,0,0,0));
        while (pst.size() > 0) begin
            drive(pst.pop_front());
            sb.push_back(pex.pop_front());
            cyc();
            e = sb.pop_front(); got = sample(); n_total++;
            if (got !== e) $display("FAIL fail_recover step%0d got %s want %s", idx, fmt(got), fmt(e));
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_lockout();
        exp_t e, got;
        int unsigned idx = 0;
        add(st(0,0,0,1,0,0), mk(0,0,0,1,0));
        add(st(0,0,0,1,0,0), mk(0,0,0,2,0));
        add(st(0,1,0,1,0,0), mk(0,1,0,3,30));
        add(st(0,0,1,0,0,0), mk(0,1,0,3,30));
        add(st(0,0,0,1,1,0), mk(0,1,0,3,30));
        for (int k = 29; k >= 1; k--) add(st(0,1,0,0,0,0), mk(0,1,0,3,k));
        add(st(0,1,0,0,0,0), mk(0,0,0,0,0));
        add(st(0,0,0,0,0,0), mk(0,0,0,0,0));
        while (pst.size() > 0) begin
            drive(pst.pop_front());
            sb.push_back(pex.pop_front());
            cyc();
            e = sb.pop_front(); got = sample(); n_total++;
            if (got !== e) $display("FAIL lockout step%0d got %s want %s", idx, fmt(got), fmt(e));
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_alarm();
        exp_t e, got;
        int unsigned idx = 0;
        add(st(0,0,0,1,0,0), mk(0,0,0,1,0));
        add(st(0,0,0,1,0,0), mk(0,0,0,2,0));
        add(st(0,0,0,1,0,0), mk(0,1,1,3,0));
        for (int i = 0; i < 100; i++)
            add(st(0,1,1'(i % 2),1,1'(i % 3 == 0),0), mk(0,1,1,3,0));
        add(st(0,0,0,0,0,1), mk(0,0,0,0,0));
        add(st(0,0,1,0,0,0), mk(1,0,0,0,0));
        add(st(0,0,0,0,0,0), mk(0,0,0,0,0));
        while (pst.size() > 0) begin
            drive(pst.pop_front());
            sb.push_back(pex.pop_front());
            cyc();
            e = sb.pop_front(); got = sample(); n_total++;
            if (got !== e) $display("FAIL alarm step%0d got %s want %s", idx, fmt(got), fmt(e));
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_simultaneous();
        exp_t e, got;
        int unsigned idx = 0;
        add(st(0,0,0,1,0,0), mk(0,0,0,1,0));
        add(st(0,0,0,1,0,0), mk(0,0,0,2,0));
        add(st(0,0,1,1,0,0), mk(1,1,0,3,30));
        add(st(0,0,0,0,0,0), mk(0,1,0,3,30));
        while (pst.size() > 0) begin
            drive(pst.pop_front());
            sb.push_back(pex.pop_front());
            cyc();
            e = sb.pop_front(); got = sample(); n_total++;
            if (got !== e) $display("FAIL simultaneous step%0d got %s want %s", idx, fmt(got), fmt(e));
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_reset_mid_lockout();
        exp_t e, got;
        int unsigned idx = 0;
        for (int k = 29; k >= 12; k--) add(st(0,1,0,0,0,0), mk(0,1,0,3,k));
        add(st(1,0,0,0,0,0), mk(0,0,0,0,0));
        add(st(0,0,1,0,0,0), mk(1,0,0,0,0));
        add(st(0,0,0,0,0,0), mk(0,0,0,0,0));
        // lock_cnt must have been cleared: a new miss streak locks out rather than alarms.
        add(st(0,0,0,1,0,0), mk(0,0,0,1,0));
        add(st(0,0,0,1,0,0), mk(0,0,0,2,0));
        add(st(0,0,0,1,0,0), mk(0,1,0,3,30));
        add(st(1,0,0,0,0,0), mk(0,0,0,0,0));
        while (pst.size() > 0) begin
            drive(pst.pop_front());
            sb.push_back(pex.pop_front());
            cyc();
            e = sb.pop_front(); got = sample(); n_total++;
            if (got !== e) $display("FAIL reset_mid_lockout step%0d got %s want %s", idx, fmt(got), fmt(e));
            else n_pass++;
            idx++;
        end
    endtask

    initial begin
        drive(st(1,0,0,0,0,0));
        test_reset();
        test_fail_recover();
        test_lockout();
        test_alarm();
        test_simultaneous();
        test_reset_mid_lockout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
